// File: rtl/ksa_swap_pkg.sv
// ksa_swap_pkg -- shared definitions for the RC4 key-scheduling swap loop.
//   KEY_LEN_DEF / RD_LAT_DEF : default parameter values for ksa_swap
//   S_DEPTH / S_WIDTH / S_AW : S-memory geometry (256 x 8) and address width
//   state_t                  : swap-loop FSM state encoding
package ksa_swap_pkg;

  localparam int KEY_LEN_DEF = 3;
  localparam int RD_LAT_DEF  = 2;
  localparam int S_DEPTH     = 256;
  localparam int S_WIDTH     = 8;
  localparam int S_AW        = $clog2(S_DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    WAIT_SI,
    CALC_J,
    RD_SJ,
    WAIT_SJ,
    WR_SI,
    WR_SJ,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/ksa_swap_if.sv
// ksa_swap_if -- S-memory port bundle.
//   address : S-memory address        (master -> slave)
//   data    : S-memory write data     (master -> slave)
//   wren    : S-memory write enable   (master -> slave)
//   q       : S-memory read data      (slave  -> master)
interface ksa_swap_if;
  import ksa_swap_pkg::*;

  logic [S_AW-1:0]    address;
  logic [S_WIDTH-1:0] data;
  logic               wren;
  logic [S_WIDTH-1:0] q;

  modport master (output address, data, wren, input q);
  modport slave  (input address, data, wren, output q);

endinterface

// File: rtl/ksa_swap.sv
// ksa_swap -- RC4 key-scheduling swap loop over a 256 x 8 S-memory.
// For i = 0..255: j = j + S[i] + key[i mod KEY_LEN]; swap S[i], S[j].
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : level, sampled only in IDLE; launches the loop
//   secret_key : key bytes, byte 0 in the most significant byte
//   mem        : S-memory bus (address/data/wren registered, q read data)
//   done       : registered, sticky until reset once the loop has finished
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, no memory traffic
// RD_SI   | address = i presented
// WAIT_SI | RD_LAT cycles of read latency for S[i]
// CALC_J  | si = q, j = j + si + key byte
// RD_SJ   | address = j presented
// WAIT_SJ | RD_LAT cycles of read latency, S[j] captured on the last one
// WR_SI   | write S[i] = sj
// WR_SJ   | write S[j] = si
// NEXT    | advance i and k, or finish after i == 255
// DONE    | done held high, leaves only by reset
module ksa_swap
  import ksa_swap_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  ksa_swap_if.master           mem,
  output logic                 done
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int WW = $clog2(RD_LAT + 1);
  localparam logic [KW-1:0]   K_LAST = KW'(KEY_LEN - 1);
  localparam logic [WW-1:0]   W_LOAD = WW'(RD_LAT);
  localparam logic [S_AW-1:0] I_LAST = S_AW'(S_DEPTH - 1);

  state_t             state;
  logic [S_AW-1:0]    i;
  logic [S_AW-1:0]    j;
  logic [KW-1:0]      k;
  logic [S_WIDTH-1:0] si;
  logic [WW-1:0]      wait_cnt;
  logic [S_WIDTH-1:0] key_byte;
  logic [S_AW-1:0]    j_next;

  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_LEN; b++) begin
      if (k == KW'(b)) key_byte = secret_key[8*(KEY_LEN-b)-1 -: 8];
    end
  end

  // 8-bit sum, carry dropped: j wraps mod 256
  assign j_next = j + mem.q + key_byte;

  // sj has no register of its own: S[j] is captured straight into the
  // write-data register, which is exactly what WR_SI needs to present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      wait_cnt    <= '0;
      mem.address <= '0;
      mem.data    <= '0;
      mem.wren    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem.wren <= 1'b0;
          if (start) begin
            mem.address <= i;
            state       <= RD_SI;
          end
        end
        RD_SI: begin
          wait_cnt <= W_LOAD;
          state    <= WAIT_SI;
        end
        WAIT_SI: begin
          if (wait_cnt == WW'(1)) state <= CALC_J;
          else wait_cnt <= wait_cnt - 1'b1;
        end
        CALC_J: begin
          si          <= mem.q;
          j           <= j_next;
          mem.address <= j_next;
          state       <= RD_SJ;
        end
        RD_SJ: begin
          wait_cnt <= W_LOAD;
          state    <= WAIT_SJ;
        end
        WAIT_SJ: begin
          if (wait_cnt == WW'(1)) begin
            mem.address <= i;
            mem.data    <= mem.q;
            mem.wren    <= 1'b1;
            state       <= WR_SI;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        WR_SI: begin
          mem.address <= j;
          mem.data    <= si;
          state       <= WR_SJ;
        end
        WR_SJ: begin
          mem.wren <= 1'b0;
          state    <= NEXT;
        end
        NEXT: begin
          if (i == I_LAST) begin
            state <= DONE;
          end else begin
            i           <= i + 1'b1;
            k           <= (k == K_LAST) ? '0 : k + 1'b1;
            mem.address <= i + 1'b1;
            state       <= RD_SI;
          end
        end
        DONE: begin
          mem.wren <= 1'b0;
          done     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap.sv
// tb_ksa_swap -- self-checking bench for ksa_swap.
// Memory model: one input register stage plus one synchronous RAM stage
// (two cycles address-to-q). Expected writes come from a software KSA model
// pushed into a queue and popped by a write monitor.
module tb_ksa_swap;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic        done;

  ksa_swap_if mem_bus ();

  ksa_swap dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .secret_key (secret_key),
    .mem        (mem_bus),
    .done       (done)
  );

  int vectors     = 0;
  int miscompares = 0;
  int wr_cnt      = 0;

  wr_t        exp_q[$];
  logic [7:0] model_s [256];
  logic [7:0] smem    [256];
  logic [7:0] addr_r, data_r;
  logic       wren_r;
  logic       mem_init;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S-memory: input register then RAM
  always @(posedge clk) begin
    addr_r <= mem_bus.address;
    data_r <= mem_bus.data;
    if (mem_init) begin
      for (int a = 0; a < 256; a++) smem[a] <= 8'(a);
      wren_r <= 1'b0;
    end else begin
      wren_r <= mem_bus.wren;
      if (wren_r) smem[addr_r] <= data_r;
      mem_bus.q <= smem[addr_r];
    end
  end

  // write monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && mem_bus.wren) begin
      wr_t got, exp;
      wr_cnt++;
      vectors++;
      got = '{a: mem_bus.address, d: mem_bus.data};
      if (exp_q.size() == 0) begin
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_write: observed addr=%h data=%h, expected no write", got.a, got.d);
        end
      end else begin
        exp = exp_q.pop_front();
        assert (got === exp) else begin
          miscompares++;
          $error("FAIL write: observed addr=%h data=%h, expected addr=%h data=%h",
                 got.a, got.d, exp.a, exp.d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [23:0] key);
    logic [7:0] j, kb, t;
    wr_t w;
    j = 8'h00;
    for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j  = j + model_s[i] + kb;
      w  = '{a: 8'(i), d: model_s[j]};
      exp_q.push_back(w);
      w  = '{a: j, d: model_s[i]};
      exp_q.push_back(w);
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endtask

  task automatic run_full(input logic [23:0] key, input bit do_reset);
    int n;
    int wr_before;
    @(negedge clk);
    if (do_reset) reset_n = 1'b0;
    mem_init = 1'b1;
    start    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n    = 1'b1;
    mem_init   = 1'b0;
    secret_key = key;
    push_model(key);
    start = 1'b1;
    @(posedge clk);  // edge that samples start
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
    chk($sformatf("done_latency key=%h", key), n, 2561);
    wr_before = wr_cnt;
    repeat (100) @(posedge clk);
    #1;
    chk("no_writes_after_done", wr_cnt - wr_before, 0);
    chk("done_sticky", done, 1);
    chk("wren_in_done", mem_bus.wren, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    for (int a = 0; a < 256; a++) chk($sformatf("final_mem[%0d]", a), smem[a], model_s[a]);
  endtask

  initial begin
    int n;
    int wr_base;
    reset_n    = 1'b0;
    start      = 1'b0;
    secret_key = 24'h0;
    mem_init   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_address", mem_bus.address, 0);
    chk("rst_data", mem_bus.data, 0);
    chk("rst_wren", mem_bus.wren, 0);
    chk("rst_done", done, 0);

    // start low for a long stretch: no traffic
    @(negedge clk);
    reset_n  = 1'b1;
    mem_init = 1'b0;
    wr_base  = wr_cnt;
    repeat (5000) @(posedge clk);
    #1;
    chk("idle_no_wren", wr_cnt - wr_base, 0);
    chk("idle_done", done, 0);

    run_full(24'h000000, 1'b1);
    run_full(24'h030201, 1'b1);
    run_full(24'hFF0000, 1'b1);
    run_full(24'h000249, 1'b1);

    // reset in the middle of iteration 100
    @(negedge clk);
    reset_n  = 1'b0;
    mem_init = 1'b1;
    start    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n    = 1'b1;
    mem_init   = 1'b0;
    secret_key = 24'h000249;
    push_model(24'h000249);
    start   = 1'b1;
    wr_base = wr_cnt;
    n = 0;
    while ((wr_cnt - wr_base) < 200 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("reach_iter100", (wr_cnt - wr_base) >= 200, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_address", mem_bus.address, 100);
    #2;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    chk("midrst_wren", mem_bus.wren, 0);
    chk("midrst_address", mem_bus.address, 0);
    chk("midrst_data", mem_bus.data, 0);
    chk("midrst_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    wr_base = wr_cnt;
    repeat (50) @(posedge clk);
    #1;
    chk("post_rst_no_writes", wr_cnt - wr_base, 0);
    chk("post_rst_wren", mem_bus.wren, 0);
    chk("post_rst_done", done, 0);

    // rerun from fresh memory without another reset: must start at i=0, j=0
    run_full(24'h000249, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
